// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared types and helpers for the modulo up/down counter
package counter_pkg;

    typedef enum logic {
        CNT_DOWN = 1'b0,
        CNT_UP   = 1'b1
    } cnt_dir_e;

    // Bits needed to hold 0..value-1, never less than one bit.
    function automatic int clog2(input int value);
        int w;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                w = i + 1;
            end
        end
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/counter_prescaler.sv
// rtl/counter_prescaler.sv - clock-enable prescaler producing the counter step strobe
module counter_prescaler
    import counter_pkg::*;
#(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int            PW   = clog2(PRESCALE);
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] r_cnt;
    logic          w_last;

    // With PRESCALE=1 LAST is zero, so the counter never leaves 0 and tick follows en.
    assign w_last = (r_cnt == LAST);
    assign tick   = en & w_last & ~clr & ~reset;

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= w_last ? '0 : r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/counter_mod_updn.sv
// rtl/counter_mod_updn.sv - modulo up/down counter with load, prescaler and wrap pulse
// Define COUNTER_SAT_EN for saturating mode instead of modulo wrap-around.
module counter_mod_updn
    import counter_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int MAX_VAL  = 9,
    parameter int PRESCALE = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic             wrap
);

    if (WIDTH < 1) begin : g_bad_width
        $error("counter_mod_updn: WIDTH must be >= 1");
    end
    if (PRESCALE < 1) begin : g_bad_prescale
        $error("counter_mod_updn: PRESCALE must be >= 1");
    end
    if (64'(MAX_VAL) > ((64'd1 << WIDTH) - 64'd1)) begin : g_bad_max
        $error("counter_mod_updn: MAX_VAL does not fit in WIDTH bits");
    end

    localparam logic [WIDTH-1:0] MAXV = WIDTH'(MAX_VAL);

    logic             w_tick;
    cnt_dir_e         w_dir;
    logic [WIDTH-1:0] w_load_q;
    logic [WIDTH-1:0] w_q_next;
    logic             w_wrap_next;
    logic [WIDTH-1:0] r_q;
    logic             r_wrap;

    counter_prescaler #(
        .PRESCALE(PRESCALE)
    ) u_prescaler (
        .clk  (clk),
        .reset(reset),
        .clr  (load),
        .en   (en),
        .tick (w_tick)
    );

    assign w_dir    = cnt_dir_e'(up_dn);
    assign w_load_q = (load_val > MAXV) ? MAXV : load_val;

    always_comb begin
        w_q_next    = r_q;
        w_wrap_next = 1'b0;
        if (load) begin
            w_q_next = w_load_q;
        end else if (w_tick) begin
            if (w_dir == CNT_UP) begin
                if (r_q == MAXV) begin
`ifdef COUNTER_SAT_EN
                    w_q_next    = MAXV;
                    w_wrap_next = 1'b0;
`else
                    w_q_next    = '0;
                    w_wrap_next = 1'b1;
`endif
                end else begin
                    w_q_next = r_q + 1'b1;
`ifdef COUNTER_SAT_EN
                    // Pulse only on the step that lands on the bound.
                    w_wrap_next = (w_q_next == MAXV);
`endif
                end
            end else begin
                if (r_q == '0) begin
`ifdef COUNTER_SAT_EN
                    w_q_next    = '0;
                    w_wrap_next = 1'b0;
`else
                    w_q_next    = MAXV;
                    w_wrap_next = 1'b1;
`endif
                end else begin
                    w_q_next = r_q - 1'b1;
`ifdef COUNTER_SAT_EN
                    w_wrap_next = (w_q_next == '0);
`endif
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_q    <= '0;
            r_wrap <= 1'b0;
        end else begin
            r_q    <= w_q_next;
            r_wrap <= w_wrap_next;
        end
    end

    assign q    = r_q;
    assign wrap = r_wrap;

endmodule

// File: tb/tb_counter_mod_updn.sv
// tb/tb_counter_mod_updn.sv - scoreboard bench for counter_mod_updn (PRESCALE 1 and 3)
module tb_counter_mod_updn;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       en = 1'b0;
    logic       up_dn = 1'b1;
    logic       load = 1'b0;
    logic [3:0] load_val = 4'd0;
    logic [3:0] q1, q3;
    logic       w1, w3;

    counter_mod_updn u_dut (
        .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load),
        .load_val(load_val), .q(q1), .wrap(w1)
    );

    counter_mod_updn #(.WIDTH(4), .MAX_VAL(9), .PRESCALE(3)) u_dut3 (
        .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load),
        .load_val(load_val), .q(q3), .wrap(w3)
    );

    always #10 clk = ~clk;

    typedef struct packed {
        logic [15:0] cyc;
        logic        inst;
        logic [3:0]  q;
        logic        w;
    } exp_t;

    exp_t sb[$];
    int   m_q[2] = '{0, 0};
    int   m_p[2] = '{0, 0};
    logic m_w[2] = '{1'b0, 1'b0};
    int   n_checks = 0;
    int   n_pass = 0;
    int   cyc_no = 0;
    int   wrap_seen = 0;

`ifdef COUNTER_SAT_EN
    localparam logic [3:0] EXP_T2 = 4'd9;
    localparam logic [3:0] EXP_T3 = 4'd0;
    localparam logic [3:0] EXP_T6U = 4'd9;
    localparam logic [3:0] EXP_T6D = 4'd0;
`else
    localparam logic [3:0] EXP_T2 = 4'd2;
    localparam logic [3:0] EXP_T3 = 4'd7;
    localparam logic [3:0] EXP_T6U = 4'd2;
    localparam logic [3:0] EXP_T6D = 4'd9;
`endif

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s cycle %0d: got %0d expected %0d", tag, cyc_no, obs, exp);
    endtask

    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            int ps;
            ps = (k == 0) ? 1 : 3;
            if (reset) begin
                m_q[k] = 0; m_p[k] = 0; m_w[k] = 1'b0;
            end else if (load) begin
                m_q[k] = (load_val > 4'd9) ? 9 : int'(load_val);
                m_p[k] = 0; m_w[k] = 1'b0;
            end else if (en && m_p[k] == ps - 1) begin
                m_p[k] = 0;
                m_w[k] = 1'b0;
                if (up_dn) begin
`ifdef COUNTER_SAT_EN
                    if (m_q[k] < 9) begin m_q[k]++; m_w[k] = (m_q[k] == 9); end
`else
                    if (m_q[k] == 9) begin m_q[k] = 0; m_w[k] = 1'b1; end else m_q[k]++;
`endif
                end else begin
`ifdef COUNTER_SAT_EN
                    if (m_q[k] > 0) begin m_q[k]--; m_w[k] = (m_q[k] == 0); end
`else
                    if (m_q[k] == 0) begin m_q[k] = 9; m_w[k] = 1'b1; end else m_q[k]--;
`endif
                end
            end else begin
                if (en) m_p[k]++;
                m_w[k] = 1'b0;
            end
            sb.push_back('{cyc_no[15:0], 1'(k), 4'(m_q[k]), m_w[k]});
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            model_edge();
            @(posedge clk);
            #1;
            while (sb.size() > 0) begin
                exp_t       e;
                logic [3:0] oq;
                logic       ow;
                e  = sb.pop_front();
                oq = e.inst ? q3 : q1;
                ow = e.inst ? w3 : w1;
                chk(e.inst ? "sb_q_ps3" : "sb_q_ps1", oq, e.q);
                chk(e.inst ? "sb_wrap_ps3" : "sb_wrap_ps1", {3'b0, ow}, {3'b0, e.w});
                if (!e.inst && ow) wrap_seen++;
            end
            cyc_no++;
        end
    endtask

    initial begin
        // Reset overrides load and en
        reset = 1'b1; en = 1'b1; load = 1'b1; load_val = 4'd5; up_dn = 1'b1;
        cyc(2);
        chk("reset_q", q1, 4'd0);
        chk("reset_wrap", {3'b0, w1}, 4'd0);
        reset = 1'b0; load = 1'b0;
        cyc(1);
        chk("first_step", q1, 4'd1);

        // Twelve up steps from 0
        reset = 1'b1; cyc(1); reset = 1'b0;
        wrap_seen = 0;
        cyc(12);
        chk("up12_q", q1, EXP_T2);
        chk("up12_wraps", 4'(wrap_seen), 4'd1);

        // Down through 0, then reverse
        reset = 1'b1; cyc(1); reset = 1'b0;
        up_dn = 1'b0;
        cyc(3);
        chk("down3_q", q1, EXP_T3);
        up_dn = 1'b1;
        cyc(3);

        // Load clamps and suppresses the step
        load = 1'b1; load_val = 4'd13; en = 1'b1;
        cyc(1);
        chk("load_clamp", q1, 4'd9);
        chk("load_wrap", {3'b0, w1}, 4'd0);
        load_val = 4'd5;
        cyc(1);
        chk("load5", q1, 4'd5);
        load = 1'b0;

        // Prescaler period, stretch by en=0, reset mid-period
        reset = 1'b1; cyc(1); reset = 1'b0;
        cyc(2);
        chk("ps3_hold", q3, 4'd0);
        cyc(1);
        chk("ps3_step1", q3, 4'd1);
        cyc(1);
        en = 1'b0; cyc(2); en = 1'b1;
        cyc(2);
        chk("ps3_stretch", q3, 4'd2);
        cyc(1);
        reset = 1'b1; cyc(1); reset = 1'b0;
        cyc(2);
        chk("ps3_restart_hold", q3, 4'd0);
        cyc(1);
        chk("ps3_restart_step", q3, 4'd1);

        // Upper and lower bound behaviour
        load = 1'b1; load_val = 4'd7; cyc(1); load = 1'b0;
        up_dn = 1'b1;
        cyc(5);
        chk("bound_up", q1, EXP_T6U);
        load = 1'b1; load_val = 4'd1; cyc(1); load = 1'b0;
        up_dn = 1'b0;
        cyc(2);
        chk("bound_down", q1, EXP_T6D);

        // Random mix
        for (int i = 0; i < 80; i++) begin
            en       = ($urandom_range(0, 3) != 0);
            up_dn    = 1'($urandom_range(0, 1));
            load     = ($urandom_range(0, 9) == 0);
            load_val = 4'($urandom_range(0, 15));
            reset    = ($urandom_range(0, 24) == 0);
            cyc(1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
